// File: rtl/bna_pkg.sv
// Shared constants for the binary accelerator output path.
// Holds the default packer geometry and the width helper used for
// beat counters and FIFO pointers.
package bna_pkg;

    localparam int IN_W_DEF       = 8;
    localparam int BEATS_DEF      = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int bnaWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = bnaWidth(BEATS_DEF);
    localparam int PTR_W_DEF = bnaWidth(FIFO_DEPTH_DEF);

endpackage

// File: rtl/bna_sync_fifo.sv
// Single-clock FIFO for the output path.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter. A push into a full FIFO is
// accepted only when a pop happens at the same edge, so the slot being
// vacated is reused. clr_i empties the FIFO synchronously.
module bna_sync_fifo
    import bna_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int PTR_W = bnaWidth(DEPTH);

    logic [PTR_W:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W:0]   rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign doPop   = pop_i & ~empty_o & ~clr_i;
    assign doPush  = push_i & ~clr_i & (~full_o | pop_i);
    assign data_o  = mem_q[rdPtr_q[PTR_W-1:0]];

    // Next pointer values: clear resets both, otherwise advance on push/pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (clr_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + 1'b1;
            if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage array; zeroed on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (doPush) begin
            mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/bin_result_packer.sv
// Packs per-lane 1-bit result beats into OUT_W-bit words and buffers them
// for the writeback side. The compute pipeline never stalls, so a word
// that finds the FIFO full (with no pop) is dropped and o_overflow sticks.
// Optional feature: define BIN_RESULT_PACKER_DROP_CNT_EN to add the
// saturating o_drop_cnt counter of discarded words.
module bin_result_packer
    import bna_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int BEATS      = BEATS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_valid,
    input  logic [IN_W-1:0]       i_data,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [IN_W*BEATS-1:0] o_data,
    output logic                  o_last,
`ifdef BIN_RESULT_PACKER_DROP_CNT_EN
    output logic [15:0]           o_drop_cnt,
`endif
    output logic                  o_overflow
);

    localparam int OUT_W = IN_W * BEATS;
    localparam int CNT_W = bnaWidth(BEATS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic             overflow_q, overflow_d;
    logic [OUT_W-1:0] wordDone;
    logic             complete;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             pop;
    logic             push;
    logic             drop;
    logic [OUT_W:0]   headEntry;

    assign complete = i_valid & ~i_clr & ((cnt_q == CNT_W'(BEATS - 1)) | i_last);
    assign pop      = ~fifoEmpty & i_ready;
    assign push     = complete & (~fifoFull | pop);
    assign drop     = complete & fifoFull & ~pop;

    // Completed word: earlier slices from asm, current beat at cnt, zeros above.
    always_comb begin
        wordDone = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (b < int'(cnt_q)) begin
                wordDone[b*IN_W +: IN_W] = asm_q[b*IN_W +: IN_W];
            end else if (b == int'(cnt_q)) begin
                wordDone[b*IN_W +: IN_W] = i_data;
            end
        end
    end

    // Beat counter and assembly register update; clear and completion restart at beat 0.
    always_comb begin
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        overflow_d = overflow_q | drop;
        if (i_clr) begin
            cnt_d      = '0;
            asm_d      = '0;
            overflow_d = 1'b0;
        end else if (i_valid) begin
            if (complete) begin
                cnt_d = '0;
                asm_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                asm_d[int'(cnt_q)*IN_W +: IN_W] = i_data;
            end
        end
    end

    // Assembly state and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
        end
    end

    bna_sync_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (i_clr),
        .push_i  (push),
        .data_i  ({i_last, wordDone}),
        .pop_i   (pop),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .data_o  (headEntry)
    );

    // Present the head word; outputs read zero while nothing is queued.
    always_comb begin
        o_valid = ~fifoEmpty;
        o_data  = '0;
        o_last  = 1'b0;
        if (!fifoEmpty) begin
            o_data = headEntry[OUT_W-1:0];
            o_last = headEntry[OUT_W];
        end
    end

    assign o_overflow = overflow_q;

`ifdef BIN_RESULT_PACKER_DROP_CNT_EN
    logic [15:0] dropCnt_q, dropCnt_d;

    // Saturating count of discarded words, cleared with the overflow flag.
    always_comb begin
        dropCnt_d = dropCnt_q;
        if (i_clr) begin
            dropCnt_d = '0;
        end else if (drop && dropCnt_q != 16'hFFFF) begin
            dropCnt_d = dropCnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dropCnt_q <= '0;
        else        dropCnt_q <= dropCnt_d;
    end

    assign o_drop_cnt = dropCnt_q;
`endif

endmodule

// File: doc/bin_result_packer.md
# bin_result_packer

Output-side stage of the binary accelerator pipeline. It consumes the valid strobe realigned by the upstream SRLC delay line together with the per-lane 1-bit results produced in the same cycle. It packs consecutive result beats into wide words and buffers them in a small FIFO. The words are presented to the writeback/DMA side over a valid/ready handshake. The compute pipeline cannot stall, so the block absorbs backpressure in the FIFO and flags any word it has to drop.

## Interface
Parameters:
- IN_W, 8, result lanes per beat (bits)
- BEATS, 4, beats packed per output word (≥2); output width OUT_W = IN_W*BEATS
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- i_clr  in  1  synchronous clear of assembly state, FIFO and overflow flag
- i_valid  in  1  beat strobe (output of the upstream delay line)
- i_data  in  IN_W  result bits for the current beat
- i_last  in  1  qualifies i_valid; final beat of a tile, forces flush
- o_valid  out  1  FIFO head holds a word
- i_ready  in  1  consumer accepts head word when o_valid & i_ready
- o_data  out  OUT_W  packed word; beat 0 in bits [IN_W-1:0]
- o_last  out  1  head word closes a tile
- o_overflow  out  1  sticky: a completed word was dropped

## Operation
- Beat counter `cnt` (0..BEATS-1) and an assembly register `asm` of OUT_W bits.
- A beat with i_valid=1 is written into `asm` slice `cnt` (lanes IN_W*cnt .. IN_W*cnt+IN_W-1).
- Word completes when i_valid & (cnt==BEATS-1 | i_last).
- Completed word = `asm` with the current beat merged in. Slices above `cnt` are forced to zero, so a partial flush is zero-padded.
- The completed word is pushed to the FIFO with its last flag = i_last. `cnt` returns to 0 and `asm` is cleared.
- Otherwise `cnt` increments on each valid beat. i_data is ignored when i_valid=0.
- Push rule: the push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle (simultaneous push+pop keeps the count unchanged).
- If the FIFO is full and there is no pop, the word is discarded, o_overflow is set, and assembly still restarts at cnt=0.
- Pop: o_valid & i_ready advances the head.
- o_data and o_last are stable while o_valid=1 and i_ready=0.
- i_clr (synchronous, highest priority after reset):
  - cnt=0, asm=0, FIFO emptied, o_overflow=0.
  - A beat arriving in the same cycle is discarded.
- States are implicit: ASSEMBLE (cnt>0), IDLE (cnt=0). No separate FSM register.

## Timing
- Reset values: o_valid=0, o_data=0, o_last=0, o_overflow=0; cnt=0, asm=0, FIFO pointers 0.
- Latency: a word completed by the beat sampled at edge k is visible at o_valid/o_data in the cycle after edge k, provided the FIFO was empty.
- Throughput: one beat per cycle sustained. The output needs i_ready=1 at least once per BEATS cycles to avoid overflow.
- o_valid falls in the cycle after the pop of the last entry, unless a push occurs at the same edge.
- rst_n asserted mid-word: the partial word and all FIFO contents are lost immediately (asynchronous). No output glitch beyond the reset values.
- i_last with cnt==BEATS-1 behaves as a normal full word with o_last=1.

## Configuration
- Macro `BIN_RESULT_PACKER_DROP_CNT_EN`.
- Defined:
  - Adds output `o_drop_cnt[15:0]`, which counts discarded words and saturates at 16'hFFFF.
  - Reset to 0 by rst_n and by i_clr.
- Undefined: the port and the counter are absent; o_overflow alone reports drops.

## Structure
- Shared package `bna_pkg`: default IN_W/BEATS/FIFO_DEPTH localparams and a `clog2`-based width constant for cnt and the FIFO pointers.
- Sub-module `bna_sync_fifo`:
  - Single-clock FIFO, width OUT_W+1 (data plus last), depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, head data.
  - Async active-low reset; reusable elsewhere in the output path.
- The top level holds the counter, the assembly register, the push/drop logic and the sticky flag.

## Test plan
- Defaults, i_ready=1:
  - Stimulus: 4 valid beats 8'h11, 8'h22, 8'h33, 8'h44, no i_last.
  - Response: a single word 32'h44332211, o_last=0, o_valid high for one cycle, one cycle after the 4th beat.
- Partial flush:
  - Stimulus: beats 8'hAA, 8'hBB with i_last on the second beat.
  - Response: word 32'h0000BBAA, o_last=1; the next word starts at beat 0.
- Backpressure:
  - Stimulus: i_ready=0, 20 consecutive valid beats (5 words).
  - Response: 4 words held in FIFO order, 5th dropped, o_overflow=1. With the macro, o_drop_cnt=1.
  - Release i_ready: words 1–4 drain in order.
- Full + pop coincident:
  - Stimulus: FIFO full, i_ready=1 in the same cycle a 5th word completes.
  - Response: no drop, o_overflow stays 0, FIFO count remains 4.
- Clear/reset mid-word:
  - Stimulus: 2 beats, then i_clr, then 4 beats 8'h01..8'h04.
  - Response: only 32'h04030201 emerges.
  - Repeat with rst_n pulsed low mid-word: all outputs go to 0 immediately.
